// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and selectable registered/FWFT read mode.
module sync_fifo_buf #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE = CW'(AE_LEVEL);
    localparam logic [CW-1:0] DP = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    logic             wr_ok, rd_ok;

    // Accept decisions depend only on registered flags, so a collision at
    // full or empty never passes data straight through.
    assign wr_ok        = wr_en && !full;
    assign rd_ok        = rd_en && !empty;
    assign full         = count == DP;
    assign empty        = count == '0;
    assign almost_full  = count >= AF;
    assign almost_empty = count <= AE;
    assign rdata        = (FWFT != 0) ? mem[rptr[AW-1:0]] : rdata_q;
    assign rvalid       = (FWFT != 0) ? !empty : rvalid_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_ok) mem[wptr[AW-1:0]] <= wdata;
            wptr      <= wptr + CW'(wr_ok);
            rptr      <= rptr + CW'(rd_ok);
            count     <= count + CW'(wr_ok) - CW'(rd_ok);
            overflow  <= (wr_en && full) || (overflow && !err_clr);
            underflow <= (rd_en && empty) || (underflow && !err_clr);
            rvalid_q  <= rd_ok;
            if (rd_ok) rdata_q <= mem[rptr[AW-1:0]];
        end
    end
endmodule

// File: tb/tb_sync_fifo_buf.sv
// tb_sync_fifo_buf: directed scoreboard bench for registered and FWFT FIFO modes.
module tb_sync_fifo_buf;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       wr_en0 = 0, rd_en0 = 0, err_clr0 = 0;
    logic       wr_en1 = 0, rd_en1 = 0, err_clr1 = 0;
    logic [7:0] rdata0, rdata1;
    logic       rvalid0, full0, empty0, af0, ae0, ovf0, unf0;
    logic       rvalid1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] count0, count1;
    int         compared = 0, mismatched = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    sync_fifo_buf #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) dut0 (
        .CLK(clk), .RST(rst), .wdata(wdata0), .wr_en(wr_en0), .rd_en(rd_en0),
        .err_clr(err_clr0), .rdata(rdata0), .rvalid(rvalid0), .full(full0),
        .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0));

    sync_fifo_buf #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) dut1 (
        .CLK(clk), .RST(rst), .wdata(wdata1), .wr_en(wr_en1), .rd_en(rd_en1),
        .err_clr(err_clr1), .rdata(rdata1), .rvalid(rvalid1), .full(full1),
        .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every registered-mode output word must match the next queued expectation.
    always @(negedge clk) begin
        if (rvalid0 === 1'b1) begin
            if (exp_q.size() == 0) chk("rdata_unexpected", 32'(rdata0), 32'hFFFF_FFFF);
            else chk("rdata_order", 32'(rdata0), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en0 = 1; wdata0 = d;
        tick();
        wr_en0 = 0;
    endtask

    task automatic rd(input logic [7:0] e);
        rd_en0 = 1; exp_q.push_back(e);
        tick();
        rd_en0 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_count", 32'(count0), 0);
        chk("rst_empty", 32'(empty0), 1);
        chk("rst_full", 32'(full0), 0);
        chk("rst_ae", 32'(ae0), 1);
        chk("rst_af", 32'(af0), 0);
        chk("rst_rvalid", 32'(rvalid0), 0);
        chk("rst_rdata", 32'(rdata0), 0);
        chk("rst_errs", 32'({ovf0, unf0}), 0);
        chk("rst_fwft_rvalid", 32'(rvalid1), 0);
        tick();
        rst = 0;
        tick();
        // FWFT instance: word appears without rd_en, pop empties it.
        wr_en1 = 1; wdata1 = 8'h5A;
        tick();
        wr_en1 = 0;
        chk("fwft_rdata", 32'(rdata1), 32'h5A);
        chk("fwft_rvalid", 32'(rvalid1), 1);
        tick();
        chk("fwft_hold", 32'(rdata1), 32'h5A);
        rd_en1 = 1;
        tick();
        rd_en1 = 0;
        chk("fwft_empty", 32'(empty1), 1);
        chk("fwft_rvalid_off", 32'(rvalid1), 0);
        // Fill
        for (int i = 1; i <= 16; i++) begin
            wr(8'(i));
            chk("fill_count", 32'(count0), 32'(i));
            chk("fill_af", 32'(af0), 32'(i >= 12));
            chk("fill_ae", 32'(ae0), 32'(i <= 4));
        end
        chk("full", 32'(full0), 1);
        // Overflow at full; contents checked by the drain order
        wr(8'hAA);
        chk("ovf_set", 32'(ovf0), 1);
        chk("ovf_count", 32'(count0), 16);
        for (int i = 1; i <= 16; i++) rd(8'(i));
        tick();
        chk("drain_empty", 32'(empty0), 1);
        chk("drain_count", 32'(count0), 0);
        rd_en0 = 1;
        tick();
        rd_en0 = 0;
        chk("unf_set", 32'(unf0), 1);
        chk("unf_rvalid", 32'(rvalid0), 0);
        err_clr0 = 1;
        tick();
        err_clr0 = 0;
        chk("clr_errs", 32'({ovf0, unf0}), 0);
        rd_en0 = 1; err_clr0 = 1;
        tick();
        rd_en0 = 0; err_clr0 = 0;
        chk("set_beats_clr", 32'(unf0), 1);
        err_clr0 = 1;
        tick();
        err_clr0 = 0;
        chk("clr_again", 32'(unf0), 0);
        // Streaming at count 5 across pointer wrap
        for (int i = 0; i < 5; i++) wr(8'(8'h20 + i));
        for (int i = 0; i < 20; i++) begin
            wr_en0 = 1; wdata0 = 8'(8'h25 + i);
            rd(8'(8'h20 + i));
            wr_en0 = 0;
            chk("stream_count", 32'(count0), 5);
        end
        for (int i = 0; i < 5; i++) rd(8'(8'h34 + i));
        tick();
        chk("stream_empty", 32'(empty0), 1);
        // Collision at empty
        wr_en0 = 1; wdata0 = 8'h77;
        rd_en0 = 1;
        tick();
        wr_en0 = 0; rd_en0 = 0;
        chk("coll_empty_count", 32'(count0), 1);
        chk("coll_empty_unf", 32'(unf0), 1);
        for (int i = 0; i < 15; i++) wr(8'(8'h78 + i));
        chk("refill_full", 32'(full0), 1);
        // Collision at full
        wr_en0 = 1; wdata0 = 8'hEE;
        rd(8'h77);
        wr_en0 = 0;
        chk("coll_full_count", 32'(count0), 15);
        chk("coll_full_ovf", 32'(ovf0), 1);
        for (int i = 0; i < 15; i++) rd(8'(8'h78 + i));
        tick();
        chk("coll_drain_empty", 32'(empty0), 1);
        err_clr0 = 1;
        tick();
        err_clr0 = 0;
        // Asynchronous reset mid-operation
        for (int i = 0; i < 9; i++) wr(8'(8'h40 + i));
        chk("pre_rst_count", 32'(count0), 9);
        #3 rst = 1;
        #1;
        chk("arst_count", 32'(count0), 0);
        chk("arst_empty", 32'(empty0), 1);
        chk("arst_full", 32'(full0), 0);
        chk("arst_ae", 32'(ae0), 1);
        chk("arst_rdata", 32'(rdata0), 0);
        chk("arst_rvalid", 32'(rvalid0), 0);
        chk("arst_errs", 32'({ovf0, unf0}), 0);
        #2 rst = 0;
        tick();
        rd_en0 = 1;
        tick();
        rd_en0 = 0;
        chk("post_rst_unf", 32'(unf0), 1);
        chk("post_rst_count", 32'(count0), 0);
        tick();
        chk("scoreboard_left", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
